// File: rtl/integrator_scheduler.sv
// Purpose: time-multiplexes one external combinational float integrator across N_CH states.
// Latency: tick to done = 1 + sum over channels of (wait_i + 2) cycles, minimum 2*N_CH+1.
// Backpressure: stalls in REQ until x_valid; tick/init_we while busy are dropped and flagged.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   tick / busy / done / overrun  sweep start, in-progress, complete pulse, dropped-tick pulse
//   x_req, x_ch / x_valid, x_data derivative request for one channel and its response
//   integ_x, integ_int_x          operands driven to the shared integrator (0 outside ACC)
//   integ_out                     integrator result, same cycle
//   init_we, init_ch, init_data   state initialisation (IDLE only), init_drop flags a drop
//   rd_ch, rd_data                combinational state readback, 0 for out-of-range channels
module integrator_scheduler #(
    parameter int          N_CH     = 8,
    parameter int          CH_W     = 3,
    parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick,
    output logic            busy,
    output logic            done,
    output logic            overrun,
    output logic            x_req,
    output logic [CH_W-1:0] x_ch,
    input  logic            x_valid,
    input  logic [31:0]     x_data,
    output logic [31:0]     integ_x,
    output logic [31:0]     integ_int_x,
    input  logic [31:0]     integ_out,
    input  logic            init_we,
    input  logic [CH_W-1:0] init_ch,
    input  logic [31:0]     init_data,
    output logic            init_drop,
    input  logic [CH_W-1:0] rd_ch,
    output logic [31:0]     rd_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    state_t          fsm;
    logic [CH_W-1:0] ch;
    logic [31:0]     bank [N_CH];

    // The channel register doubles as the request channel output.
    assign x_ch = ch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm         <= IDLE;
            ch          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
            init_drop   <= 1'b0;
            x_req       <= 1'b0;
            integ_x     <= '0;
            integ_int_x <= '0;
            for (int i = 0; i < N_CH; i++) begin
                bank[i] <= INIT_VAL;
            end
        end else begin
            done      <= 1'b0;
            overrun   <= 1'b0;
            init_drop <= 1'b0;

            case (fsm)
                IDLE: begin
                    // The init write lands on this edge, before the sweep can read
                    // any channel, so a same-cycle tick sees the new value.
                    if (init_we && (int'(init_ch) < N_CH)) begin
                        bank[init_ch] <= init_data;
                    end
                    if (tick) begin
                        fsm   <= REQ;
                        ch    <= '0;
                        busy  <= 1'b1;
                        x_req <= 1'b1;
                    end
                end
                REQ: begin
                    // integ_x is the captured derivative register; the state operand
                    // is captured alongside so both are registered during ACC.
                    if (x_valid) begin
                        fsm         <= ACC;
                        x_req       <= 1'b0;
                        integ_x     <= x_data;
                        integ_int_x <= bank[ch];
                    end
                end
                ACC: begin
                    bank[ch]    <= integ_out;
                    integ_x     <= '0;
                    integ_int_x <= '0;
                    if (ch == LAST_CH) begin
                        fsm  <= DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        fsm   <= REQ;
                        ch    <= ch + CH_W'(1);
                        x_req <= 1'b1;
                    end
                end
                DONE: begin
                    fsm <= IDLE;
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase

            // Any tick or init request outside IDLE is discarded and reported.
            if (fsm != IDLE) begin
                overrun   <= tick;
                init_drop <= init_we;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (int'(rd_ch) < N_CH) begin
            rd_data = bank[rd_ch];
        end
    end

endmodule

// File: tb/tb_integrator_scheduler.sv
// Purpose: randomized scoreboard bench for integrator_scheduler with a float integrator model.
// Latency: checks tick-to-done cycle count against the per-channel wait schedule.
// Backpressure: drives x_valid with programmable per-channel delays.
module tb_integrator_scheduler;

    localparam int          N_CH     = 8;
    localparam int          CH_W     = 3;
    localparam logic [31:0] INIT_VAL = 32'h0000_0000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            tick = 1'b0;
    logic            busy;
    logic            done;
    logic            overrun;
    logic            x_req;
    logic [CH_W-1:0] x_ch;
    logic            x_valid = 1'b0;
    logic [31:0]     x_data = '0;
    logic [31:0]     integ_x;
    logic [31:0]     integ_int_x;
    logic [31:0]     integ_out;
    logic            init_we = 1'b0;
    logic [CH_W-1:0] init_ch = '0;
    logic [31:0]     init_data = '0;
    logic            init_drop;
    logic [CH_W-1:0] rd_ch = '0;
    logic [31:0]     rd_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    integrator_scheduler #(
        .N_CH(N_CH), .CH_W(CH_W), .INIT_VAL(INIT_VAL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .busy(busy), .done(done),
        .overrun(overrun), .x_req(x_req), .x_ch(x_ch), .x_valid(x_valid),
        .x_data(x_data), .integ_x(integ_x), .integ_int_x(integ_int_x),
        .integ_out(integ_out), .init_we(init_we), .init_ch(init_ch),
        .init_data(init_data), .init_drop(init_drop), .rd_ch(rd_ch),
        .rd_data(rd_data)
    );

    // Float32 <-> real helpers (normals only; denormals and underflow flush to zero).
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        int          e;
        if (f[30:23] == 8'd0) return 0.0;
        e = int'(f[30:23]) - 127 + 1023;
        d = {f[31], e[10:0], f[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int          e;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        if (d[62:52] == 11'd0 || e <= 0) return {d[63], 31'b0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // External integrator: out = x * 2^-10 + int_x.
    function automatic logic [31:0] integ(input logic [31:0] x, input logic [31:0] ix);
        return r2f(f2r(x) / 1024.0 + f2r(ix));
    endfunction

    always_comb integ_out = integ(integ_x, integ_int_x);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=event expected=none", name);
    endtask

    // Scoreboard queues filled by stimulus, drained by the monitor.
    typedef struct {
        int          ch;
        logic [31:0] x;
        logic [31:0] ix;
    } acc_t;

    acc_t acc_q[$];
    int   lat_q[$];
    acc_t mon_a;

    logic [31:0] ref_st [N_CH];
    logic [31:0] sx [N_CH];
    int          sw [N_CH];

    int   neg_cyc    = 0;
    int   start_cyc  = 0;
    logic sweep_tick = 1'b0;
    int   ov_cnt     = 0;
    int   drop_cnt   = 0;

    always @(negedge clk) begin
        neg_cyc++;
        if (rst_n) begin
            if (tick && sweep_tick) start_cyc = neg_cyc;
            if (busy && !x_req) begin
                if (acc_q.size() == 0) begin
                    flag("unexpected_acc");
                end else begin
                    mon_a = acc_q.pop_front();
                    check("acc_ch", 32'(x_ch), 32'(mon_a.ch));
                    check("acc_integ_x", integ_x, mon_a.x);
                    check("acc_integ_int_x", integ_int_x, mon_a.ix);
                end
            end else if (busy) begin
                check("req_integ_x_zero", integ_x, 32'h0);
                check("req_integ_int_x_zero", integ_int_x, 32'h0);
            end
            if (done) begin
                if (lat_q.size() == 0) begin
                    flag("unexpected_done");
                end else begin
                    check("latency", 32'(neg_cyc - start_cyc), 32'(lat_q.pop_front()));
                    check("done_busy", 32'(busy), 32'h0);
                end
            end
            if (overrun) ov_cnt++;
            if (init_drop) drop_cnt++;
        end
    end

    task automatic check_states(input string name);
        for (int c = 0; c < N_CH; c++) begin
            rd_ch = CH_W'(c);
            #1;
            check(name, rd_data, ref_st[c]);
        end
    endtask

    task automatic do_init(input int c, input logic [31:0] v);
        @(posedge clk); #1;
        init_we = 1'b1; init_ch = CH_W'(c); init_data = v;
        @(posedge clk); #1;
        init_we = 1'b0;
        ref_st[c] = v;
    endtask

    // One sweep using sx/sw. init_c>=0 writes in the tick cycle; inj_ch>=0 injects
    // tick+init_we during that channel's ACC; abort_ch>=0 resets in that ACC.
    task automatic sweep(input bit hold, input int init_c, input logic [31:0] init_v,
                         input int inj_ch, input int abort_ch);
        int lat;
        lat = 1;
        if (init_c >= 0) ref_st[init_c] = init_v;
        for (int c = 0; c < N_CH; c++) begin
            if (abort_ch < 0 || c < abort_ch) begin
                acc_q.push_back('{c, sx[c], ref_st[c]});
                ref_st[c] = integ(sx[c], ref_st[c]);
            end
            lat += sw[c] + 2;
        end
        if (abort_ch < 0) lat_q.push_back(lat);

        @(posedge clk); #1;
        tick = 1'b1; sweep_tick = 1'b1;
        if (init_c >= 0) begin
            init_we = 1'b1; init_ch = CH_W'(init_c); init_data = init_v;
        end
        if (hold) begin
            x_valid = 1'b1; x_data = 32'hC000_0000;
        end
        @(posedge clk); #1;
        tick = 1'b0; sweep_tick = 1'b0; init_we = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            for (int w = 0; w < sw[c]; w++) begin
                check("req_wait", 32'({x_req, x_ch}), 32'({1'b1, CH_W'(c)}));
                x_valid = 1'b0;
                @(posedge clk); #1;
            end
            check("req", 32'({x_req, x_ch}), 32'({1'b1, CH_W'(c)}));
            x_valid = 1'b1; x_data = sx[c];
            @(posedge clk); #1;
            if (!hold) x_valid = 1'b0;
            if (c == abort_ch) begin
                rst_n = 1'b0;
                #1;
                check("abort_busy", 32'(busy), 32'h0);
                x_valid = 1'b0;
                return;
            end
            if (c == inj_ch) begin
                tick = 1'b1; init_we = 1'b1; init_ch = CH_W'(c); init_data = 32'h4100_0000;
            end
            @(posedge clk); #1;
            if (c == inj_ch) begin
                check("overrun_pulse", 32'(overrun), 32'h1);
                check("init_drop_pulse", 32'(init_drop), 32'h1);
                tick = 1'b0; init_we = 1'b0;
            end
        end
        x_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic fill(input logic [31:0] v);
        for (int c = 0; c < N_CH; c++) begin
            sx[c] = v;
            sw[c] = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ov0, dr0;
        for (int c = 0; c < N_CH; c++) ref_st[c] = INIT_VAL;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_init_drop", 32'(init_drop), 32'h0);
        check("rst_x_req", 32'(x_req), 32'h0);
        check("rst_x_ch", 32'(x_ch), 32'h0);
        check("rst_integ_x", integ_x, 32'h0);
        check("rst_integ_int_x", integ_int_x, 32'h0);
        check_states("rst_state");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // T1/T2: x=1.0 twice, then x=-1.0, x_valid held high throughout.
        fill(32'h3F80_0000);
        sweep(1'b1, -1, '0, -1, -1);
        check_states("t1_state");
        check("t1_const", rd_data, 32'h3A80_0000);
        sweep(1'b1, -1, '0, -1, -1);
        check_states("t2_state");
        check("t2_const", rd_data, 32'h3B00_0000);
        fill(32'hBF80_0000);
        sweep(1'b1, -1, '0, -1, -1);
        check_states("t2b_state");
        check("t2b_const", rd_data, 32'h3A80_0000);

        // T3: init ch3 then a zero-derivative sweep.
        do_init(3, 32'h4000_0000);
        fill(32'h0000_0000);
        sweep(1'b0, -1, '0, -1, -1);
        check_states("t3_state");
        rd_ch = CH_W'(3);
        #1;
        check("t3_ch3", rd_data, 32'h4000_0000);

        // T4: five-cycle x_valid delay on ch2.
        fill(32'h3F80_0000);
        sw[2] = 5;
        sweep(1'b0, -1, '0, -1, -1);
        check_states("t4_state");

        // T5: tick and init_we mid-sweep are dropped and reported once each.
        ov0 = ov_cnt; dr0 = drop_cnt;
        fill(32'h3F80_0000);
        sweep(1'b0, -1, '0, 3, -1);
        check_states("t5_state");
        check("t5_overrun_cnt", 32'(ov_cnt - ov0), 32'h1);
        check("t5_drop_cnt", 32'(drop_cnt - dr0), 32'h1);

        // Same-cycle tick and init: the sweep integrates on top of the new value.
        fill(32'h3F80_0000);
        sweep(1'b0, 5, 32'h4040_0000, -1, -1);
        check_states("same_cycle_init_state");

        // Randomized sweeps.
        for (int k = 0; k < 30; k++) begin
            int ic;
            for (int c = 0; c < N_CH; c++) begin
                sx[c] = {1'($urandom_range(0, 1)), 8'($urandom_range(118, 134)), 23'($urandom)};
                sw[c] = int'($urandom_range(0, 3));
            end
            ic = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N_CH - 1)) : -1;
            sweep(1'($urandom_range(0, 1)), ic,
                  {1'b0, 8'($urandom_range(120, 130)), 23'($urandom)},
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N_CH - 1)) : -1, -1);
            check_states("rand_state");
        end

        // T6: reset during ACC of ch4 aborts the sweep without a done pulse.
        fill(32'h3F80_0000);
        sweep(1'b0, -1, '0, -1, 4);
        for (int c = 0; c < N_CH; c++) ref_st[c] = INIT_VAL;
        check_states("t6_state_in_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_x_req", 32'(x_req), 32'h0);
        check_states("t6_state");

        check("acc_q_empty", 32'(acc_q.size()), 32'h0);
        check("lat_q_empty", 32'(lat_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
